mem2048_rd_port: RTL

- 2048 x n-bit storage array with one synchronous write port and one registered, handshaked read port.
- The read path indexes the array through the 2048:1 mux tree (mux2048to1_n).
- A one-entry output register decouples the mux path from the consumer, so the combinational tree never drives a downstream pipeline stage directly.
- Sits between the datapath's load/store unit and the 2048-word data/instruction store.

---
 rtl/mem2048_pkg.sv | 12 +
 rtl/mem2048_rd_port_if.sv | 31 +++
 rtl/mux2048to1_n.sv | 12 +
 rtl/mem2048_rd_port.sv | 81 ++++++++
 4 files changed

// File: rtl/mem2048_pkg.sv
// Shared constants and types for the 2048-word read port.
package mem2048_pkg;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rd_state_t;
endpackage

// File: rtl/mem2048_rd_port_if.sv
// Write port plus read request/response handshake for mem2048_rd_port.
interface mem2048_rd_port_if #(
    parameter int N     = 4,
    parameter int CNT_W = 16
);
    import mem2048_pkg::*;

    logic             wr_en_i;
    addr_t            wr_addr_i;
    logic [N-1:0]     wr_data_i;
    logic             req_valid_i;
    logic             req_ready_o;
    addr_t            req_addr_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [N-1:0]     rsp_data_o;
    addr_t            rsp_addr_o;
    logic [CNT_W-1:0] rd_cnt_o;

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i,
        input  req_valid_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rd_cnt_o
    );

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i,
        output req_valid_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rd_cnt_o
    );
endinterface

// File: rtl/mux2048to1_n.sv
// 2048:1 word-select mux; the index expression maps onto a balanced mux tree.
module mux2048to1_n
    import mem2048_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] data [DEPTH],
    input  addr_t        sel,
    output logic [n-1:0] y
);
    assign y = data[sel];
endmodule

// File: rtl/mem2048_rd_port.sv
// 2048 x N storage with a synchronous write port and a one-entry registered read port.
// Define MEM2048_RD_PORT_BYPASS_EN to make a same-cycle read of the written address return the new word.
module mem2048_rd_port
    import mem2048_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem2048_rd_port_if.slave   bus
);
    logic [N-1:0]     mem [DEPTH];
    logic [N-1:0]     mux_y;
    logic [N-1:0]     cap_data;
    logic [N-1:0]     rsp_data;
    addr_t            rsp_addr;
    logic [CNT_W-1:0] rd_cnt;
    rd_state_t        state, state_nxt;
    logic             accept, retire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.wr_en_i) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    mux2048to1_n #(.n(N)) u_mux (
        .data (mem),
        .sel  (bus.req_addr_i),
        .y    (mux_y)
    );

`ifdef MEM2048_RD_PORT_BYPASS_EN
    // Write-first: the word being written this cycle wins over the array copy.
    assign cap_data = (bus.wr_en_i && (bus.wr_addr_i == bus.req_addr_i)) ? bus.wr_data_i : mux_y;
`else
    assign cap_data = mux_y;
`endif

    assign bus.req_ready_o = (state == EMPTY) || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign retire          = (state == FULL) && bus.rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (retire && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Only an accept reloads the register, so data/addr hold under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data <= '0;
            rsp_addr <= '0;
        end else if (accept) begin
            rsp_data <= cap_data;
            rsp_addr <= bus.req_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    rd_cnt <= '0;
        else if (retire && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
    end

    assign bus.rsp_valid_o = (state == FULL);
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_addr_o  = rsp_addr;
    assign bus.rd_cnt_o    = rd_cnt;
endmodule
